// File: rtl/melody_pkg.sv
// Shared definitions for the melody player: tone codes, ROM entry layout and FSM states.
package melody_pkg;

  localparam logic [3:0] TONE_NONE = 4'd0;
  localparam logic [3:0] TONE_C3   = 4'd1;
  localparam logic [3:0] TONE_D3   = 4'd2;
  localparam logic [3:0] TONE_E3   = 4'd3;
  localparam logic [3:0] TONE_F3   = 4'd4;
  localparam logic [3:0] TONE_G3   = 4'd5;
  localparam logic [3:0] TONE_A3   = 4'd6;
  localparam logic [3:0] TONE_B3   = 4'd7;
  localparam logic [3:0] TONE_C4   = 4'd8;
  localparam logic [3:0] TONE_D4   = 4'd9;
  localparam logic [3:0] TONE_E4   = 4'd10;
  localparam logic [3:0] TONE_F4   = 4'd11;
  localparam logic [3:0] TONE_G4   = 4'd12;
  localparam logic [3:0] TONE_A4   = 4'd13;
  localparam logic [3:0] TONE_B4   = 4'd14;
  localparam logic [3:0] TONE_C5   = 4'd15;

  localparam int ENTRY_W   = 8;
  localparam int TONE_MSB  = 7;
  localparam int TONE_LSB  = 4;
  localparam int BEATS_MSB = 3;
  localparam int BEATS_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    PLAY,
    GAP
  } state_t;

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [3:0] t, input logic [3:0] b);
    return {t, b};
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Song table ROM: 4 songs x 16 entries, address {song, idx}, one-cycle read latency.
module melody_rom
  import melody_pkg::*;
(
  input  logic       clk,
  input  logic [5:0] addr,
  output logic [7:0] data
);

  logic [7:0] data_d;
  logic [7:0] data_q;

  always_comb begin
    data_d = '0;
    case (addr)
      // Song 0: start jingle
      6'h00: data_d = mk_entry(TONE_C4, 4'd1);
      6'h01: data_d = mk_entry(TONE_E4, 4'd1);
      6'h02: data_d = mk_entry(TONE_G4, 4'd1);
      6'h03: data_d = mk_entry(TONE_C5, 4'd2);
      // Song 1: player-1 fanfare
      6'h10: data_d = mk_entry(TONE_G4, 4'd1);
      6'h11: data_d = mk_entry(TONE_C5, 4'd1);
      6'h12: data_d = mk_entry(TONE_G4, 4'd1);
      6'h13: data_d = mk_entry(TONE_C5, 4'd3);
      // Song 2: player-2 fanfare, all 16 slots used (no end marker)
      6'h20: data_d = mk_entry(TONE_G3, 4'd1);
      6'h21: data_d = mk_entry(TONE_B3, 4'd1);
      6'h22: data_d = mk_entry(TONE_D4, 4'd1);
      6'h23: data_d = mk_entry(TONE_E4, 4'd1);
      6'h24: data_d = mk_entry(TONE_G3, 4'd1);
      6'h25: data_d = mk_entry(TONE_B3, 4'd1);
      6'h26: data_d = mk_entry(TONE_D4, 4'd1);
      6'h27: data_d = mk_entry(TONE_NONE, 4'd1);
      6'h28: data_d = mk_entry(TONE_G4, 4'd1);
      6'h29: data_d = mk_entry(TONE_E4, 4'd1);
      6'h2A: data_d = mk_entry(TONE_D4, 4'd1);
      6'h2B: data_d = mk_entry(TONE_B3, 4'd1);
      6'h2C: data_d = mk_entry(TONE_G3, 4'd1);
      6'h2D: data_d = mk_entry(TONE_E3, 4'd1);
      6'h2E: data_d = mk_entry(TONE_C3, 4'd1);
      6'h2F: data_d = mk_entry(TONE_B4, 4'd1);
      default: data_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the song ROM, presenting each note's tone code for its beats, then a silent gap.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int BEAT_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 1250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] song,
  input  logic       stop,
  output logic [3:0] tone,
  output logic       busy,
  output logic       done
);

  localparam int CYC_MAX = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam logic [CYC_W-1:0] BEAT_LAST = CYC_W'(BEAT_CYCLES - 1);
  localparam logic [CYC_W-1:0] GAP_LAST  = CYC_W'(GAP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       song_q, song_d;
  logic [3:0]       idx_q, idx_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [3:0]       beat_left_q, beat_left_d;
  logic [3:0]       tone_q, tone_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [7:0] rom_data;
  logic [3:0] rom_tone;
  logic [3:0] rom_beats;

  melody_rom u_rom (
    .clk  (clk),
    .addr ({song_q, idx_q}),
    .data (rom_data)
  );

  assign rom_tone  = rom_data[TONE_MSB:TONE_LSB];
  assign rom_beats = rom_data[BEATS_MSB:BEATS_LSB];

  always_comb begin
    state_d     = state_q;
    song_d      = song_q;
    idx_d       = idx_q;
    cyc_d       = cyc_q;
    beat_left_d = beat_left_q;
    tone_d      = tone_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      tone_d  = TONE_NONE;
      busy_d  = 1'b0;
      cyc_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          tone_d = TONE_NONE;
          busy_d = 1'b0;
          if (start && !stop) begin
            song_d  = song;
            idx_d   = '0;
            busy_d  = 1'b1;
            state_d = FETCH;
          end
        end
        FETCH: state_d = DECODE;
        DECODE: begin
          if (rom_beats == 4'd0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            tone_d  = TONE_NONE;
            state_d = IDLE;
          end else begin
            tone_d      = rom_tone;
            beat_left_d = rom_beats;
            cyc_d       = '0;
            state_d     = PLAY;
          end
        end
        PLAY: begin
          if (cyc_q == BEAT_LAST) begin
            cyc_d       = '0;
            beat_left_d = beat_left_q - 4'd1;
            if (beat_left_q == 4'd1) begin
              tone_d  = TONE_NONE;
              state_d = GAP;
            end
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        GAP: begin
          if (cyc_q == GAP_LAST) begin
            cyc_d = '0;
            if (idx_q == 4'd15) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = FETCH;
            end
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tone_d  = TONE_NONE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      song_q      <= '0;
      idx_q       <= '0;
      cyc_q       <= '0;
      beat_left_q <= '0;
      tone_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      song_q      <= song_d;
      idx_q       <= idx_d;
      cyc_q       <= cyc_d;
      beat_left_q <= beat_left_d;
      tone_q      <= tone_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tone = tone_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: directed table, hand sequences and random traffic vs a trace model.
module tb_melody_sequencer;

  localparam int BEAT = 4;
  localparam int GAPC = 2;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [1:0] song;
  logic [3:0] tone;
  logic       busy, done;

  melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAPC)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .song  (song),
    .stop  (stop),
    .tone  (tone),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] tone;
    logic       busy;
    logic       done;
  } obs_t;

  localparam obs_t IDLE_OBS = '{tone: 4'd0, busy: 1'b0, done: 1'b0};

  obs_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] song_tab [4][16];

  // Expected per-edge outputs for a whole song, starting with the edge that accepts start.
  function automatic void load_song(input logic [1:0] s);
    logic [7:0] e;
    int n;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      e = song_tab[s][i];
      exp_q.push_back('{tone: 4'd0, busy: 1'b1, done: 1'b0});
      exp_q.push_back('{tone: 4'd0, busy: 1'b1, done: 1'b0});
      if (e[3:0] == 4'd0) begin
        exp_q.push_back('{tone: 4'd0, busy: 1'b0, done: 1'b1});
        return;
      end
      n = int'(e[3:0]) * BEAT;
      for (int k = 0; k < n; k++) exp_q.push_back('{tone: e[7:4], busy: 1'b1, done: 1'b0});
      for (int k = 0; k < GAPC; k++) exp_q.push_back('{tone: 4'd0, busy: 1'b1, done: 1'b0});
      if (i == 15) exp_q.push_back('{tone: 4'd0, busy: 1'b0, done: 1'b1});
    end
  endfunction

  function automatic obs_t model_step(input logic r, input logic st, input logic sp,
                                      input logic [1:0] sg);
    if (!r) begin
      exp_q.delete();
      return IDLE_OBS;
    end
    if (exp_q.size() != 0) begin
      if (sp) begin
        exp_q.delete();
        return IDLE_OBS;
      end
      return exp_q.pop_front();
    end
    if (st && !sp) begin
      load_song(sg);
      return exp_q.pop_front();
    end
    return IDLE_OBS;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got tone=%0d busy=%0b done=%0b, expected tone=%0d busy=%0b done=%0b",
               name, $time, got.tone, got.busy, got.done, exp.tone, exp.busy, exp.done);
    end
  endtask

  task automatic step(input logic r, input logic st, input logic sp, input logic [1:0] sg,
                      input string name);
    obs_t e;
    rst   = r;
    start = st;
    stop  = sp;
    song  = sg;
    e = model_step(r, st, sp, sg);
    @(posedge clk);
    #1;
    check(name, '{tone: tone, busy: busy, done: done}, e);
  endtask

  task automatic idle_steps(input int n, input string name);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 2'd0, name);
  endtask

  typedef struct {
    logic       r, st, sp;
    logic [1:0] sg;
    logic [3:0] t;
    logic       b, d;
  } vec_t;

  vec_t vt[14];

  initial begin
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 16; i++) song_tab[s][i] = 8'h00;
    song_tab[0][0] = 8'h81; song_tab[0][1] = 8'hA1; song_tab[0][2] = 8'hC1; song_tab[0][3] = 8'hF2;
    song_tab[1][0] = 8'hC1; song_tab[1][1] = 8'hF1; song_tab[1][2] = 8'hC1; song_tab[1][3] = 8'hF3;
    song_tab[2][0]  = 8'h51; song_tab[2][1]  = 8'h71; song_tab[2][2]  = 8'h91; song_tab[2][3]  = 8'hA1;
    song_tab[2][4]  = 8'h51; song_tab[2][5]  = 8'h71; song_tab[2][6]  = 8'h91; song_tab[2][7]  = 8'h01;
    song_tab[2][8]  = 8'hC1; song_tab[2][9]  = 8'hA1; song_tab[2][10] = 8'h91; song_tab[2][11] = 8'h71;
    song_tab[2][12] = 8'h51; song_tab[2][13] = 8'h31; song_tab[2][14] = 8'h11; song_tab[2][15] = 8'hE1;

    // reset held with start, release, start+stop conflict, empty song 3, start then stop
    vt[0]  = '{1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 2'd3, 4'd0, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1};
    vt[10] = '{1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b1, 1'b0};
    vt[12] = '{1'b1, 1'b0, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0};
    vt[13] = '{1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0};

    rst = 1'b0; start = 1'b0; stop = 1'b0; song = 2'd0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      step(vt[i].r, vt[i].st, vt[i].sp, vt[i].sg, "table_model");
      check("table_vec", '{tone: tone, busy: busy, done: done},
            '{tone: vt[i].t, busy: vt[i].b, done: vt[i].d});
    end

    // Song 0 in full
    step(1'b1, 1'b1, 1'b0, 2'd0, "song0_start");
    idle_steps(2, "song0");
    check("song0_first_note", '{tone: tone, busy: busy, done: done}, '{tone: 4'd8, busy: 1'b1, done: 1'b0});
    idle_steps(45, "song0");

    // Stop during the tone=10 note, restart one cycle later
    step(1'b1, 1'b1, 1'b0, 2'd0, "stop_start");
    idle_steps(11, "stop_pre");
    check("stop_on_tone10", '{tone: tone, busy: busy, done: done}, '{tone: 4'd10, busy: 1'b1, done: 1'b0});
    step(1'b1, 1'b0, 1'b1, 2'd0, "stop_edge");
    check("stop_idle", '{tone: tone, busy: busy, done: done}, IDLE_OBS);
    idle_steps(1, "stop_after");
    step(1'b1, 1'b1, 1'b0, 2'd0, "restart");
    idle_steps(2, "restart");
    check("restart_tone8", '{tone: tone, busy: busy, done: done}, '{tone: 4'd8, busy: 1'b1, done: 1'b0});
    idle_steps(45, "restart_rest");

    // start of song 1 while song 0 plays is ignored
    step(1'b1, 1'b1, 1'b0, 2'd0, "ign_start");
    idle_steps(4, "ign_pre");
    step(1'b1, 1'b1, 1'b0, 2'd1, "ign_req");
    idle_steps(45, "ign_rest");

    // Reset during the first gap
    step(1'b1, 1'b1, 1'b0, 2'd0, "rstgap_start");
    idle_steps(6, "rstgap_pre");
    step(1'b0, 1'b1, 1'b1, 2'd1, "rstgap_reset");
    check("rstgap_idle", '{tone: tone, busy: busy, done: done}, IDLE_OBS);
    idle_steps(6, "rstgap_post");

    // Songs 1 and 2 (song 2 uses all 16 slots)
    step(1'b1, 1'b1, 1'b0, 2'd1, "song1_start");
    idle_steps(60, "song1");
    step(1'b1, 1'b1, 1'b0, 2'd2, "song2_start");
    idle_steps(140, "song2");

    // Back-to-back: start on the cycle after done
    step(1'b1, 1'b1, 1'b0, 2'd3, "b2b_a");
    idle_steps(1, "b2b_a");
    step(1'b1, 1'b0, 1'b0, 2'd0, "b2b_done");
    step(1'b1, 1'b1, 1'b0, 2'd3, "b2b_b");
    idle_steps(3, "b2b_b");

    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 300) != 0, ($urandom % 10) == 0, ($urandom % 60) == 0,
           2'($urandom_range(0, 3)), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Plays short stored melodies by driving a 4-bit tone code into the tone_generator stage, one note at a time, for a programmed number of beats. Sits directly upstream of tone_generator: game logic requests a song (start jingle, player-1 win, player-2 win), and this block steps through a small ROM. It presents each note's tone code for its duration, inserts a silent gap between notes, and reports completion.

## Interface
- BEAT_CYCLES, 12500000: clk cycles per beat (250 ms at 50 MHz); must be ≥ 1.
- GAP_CYCLES, 1250000: silent cycles after each note (25 ms); must be ≥ 1.
- clk  in  1  system clock, single clock domain.
- rst  in  1  reset: synchronous, active-low. While low at a rising clk edge, all state is cleared.
- start  in  1  one-cycle request to play `song`; sampled only in IDLE.
- song  in  2  song select, latched when start is accepted.
- stop  in  1  abort playback; effective in any state.
- tone  out  4  tone code to tone_generator; 0 = TONE_NONE (silence); registered.
- busy  out  1  high from accepted start until return to IDLE; registered.
- done  out  1  one-cycle pulse on normal song completion; registered.

## Operation
- ROM entry is 8 bits: [7:4] tone code, [3:0] beats.
  - beats = 0 is the end-of-song marker.
  - tone = 0 with beats > 0 is a rest.
- Address is {song, idx[3:0]}, so each song has at most 16 entries.
- Song contents:
  - Song 0: (8,1) (10,1) (12,1) (15,2) (0,0) — C4 E4 G4 C5.
  - Song 3: (0,0) — empty.
  - Songs 1 and 2: win fanfares, each ≤ 16 entries.
- States:
  - IDLE: tone=0, busy=0. On start=1 and stop=0: latch song, idx←0, go to FETCH.
  - FETCH: ROM address presented, go to DECODE.
  - DECODE: ROM data valid.
    - If beats=0: done←1, go to IDLE.
    - Else: tone←entry tone, beat_left←beats, cyc←0, go to PLAY.
  - PLAY: cyc counts 0..BEAT_CYCLES-1. At wrap, beat_left decrements. When the last beat wraps: tone←0, cyc←0, go to GAP.
  - GAP: cyc counts 0..GAP_CYCLES-1. At the end:
    - If idx=15: done←1, go to IDLE. A full 16-entry song ends with no marker.
    - Else: idx←idx+1, go to FETCH.
- stop=1 in any non-IDLE state: next edge goes to IDLE with tone=0 and busy=0; done is not asserted.
- start while busy is ignored.
- start and stop in the same IDLE cycle: stop wins, start is ignored.
- Counter widths: cyc is $clog2(max(BEAT_CYCLES, GAP_CYCLES)) bits; beat_left is 4 bits. No overflow is possible.

## Timing
- Reset values: tone=0, busy=0, done=0, state=IDLE, idx=0, all counters 0.
- rst low mid-song: the next edge produces the reset values; this overrides stop and start.
- start accepted at edge k:
  - busy=1 after edge k.
  - FETCH at k, DECODE at k+1.
  - tone valid after edge k+2.
- A note occupies tone for exactly beats × BEAT_CYCLES cycles.
- Inter-note silence is exactly GAP_CYCLES + 2 cycles (gap, then FETCH and DECODE).
- End marker: done is high for exactly one cycle. busy falls on the same edge done rises. tone is already 0.
- A new start is accepted on the cycle after done; back-to-back songs are allowed.

## Structure
- Shared package melody_pkg holds:
  - Tone code constants TONE_NONE..TONE_C5 (0..15), also used by tone_generator.
  - Entry field widths and positions.
  - State enum: IDLE, FETCH, DECODE, PLAY, GAP.
- Sub-module melody_rom:
  - 64×8 synchronous-read ROM; input addr[5:0], output data[7:0].
  - One-cycle read latency.
  - Holds the song tables.
- melody_sequencer contains the FSM, counters and output registers.

## Test plan
Bench parameters: BEAT_CYCLES=4, GAP_CYCLES=2.
- Reset: hold rst=0 for 3 cycles with start=1 → tone=0, busy=0, done=0 throughout. No playback after release until a fresh start.
- Song 0: pulse start at edge 0 → busy=1. Then:
  - tone=8 for 4 cycles starting after edge 2.
  - 0 for 4 cycles.
  - 10 ×4, 0 ×4, 12 ×4, 0 ×4, 15 ×8, 0 ×4.
  - done pulse, one cycle, coincident with busy falling.
- Song 3: start → busy high for 2 cycles, tone stays 0, then a done pulse.
- Stop mid-note: start song 0, assert stop during the tone=10 note → next edge tone=0 and busy=0; done never asserts. A start 1 cycle later replays from tone=8.
- Ignored and conflicting requests:
  - start (song=1) during song 0 → song 0 sequence unchanged.
  - start and stop together in IDLE → stays IDLE.
- Reset mid-song: drive rst=0 during a GAP → next edge gives all outputs 0 and state IDLE. After release, the block idles until a new start.
